// File: rtl/ccu_isa_fetch_arb_pkg.sv
// Shared types and constants for the CCU ISA fetch scheduler.
// Opcode enum, per-module instruction sizes, FSM state encoding.
package ccu_isa_fetch_arb_pkg;

    localparam int NUM_OPS      = 6;
    localparam int OPCODE_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_FPS = 3'd0,
        OP_KNN = 3'd1,
        OP_SYA = 3'd2,
        OP_POL = 3'd3,
        OP_GIC = 3'd4,
        OP_MON = 3'd5
    } opcode_e;

    // Beats per instruction, indexed by opcode
    localparam logic [7:0] ISA_WORDS [NUM_OPS] = '{
        8'd16, 8'd2, 8'd3, 8'd9, 8'd2, 8'd1
    };

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_REQ  = 3'd2,
        S_XFER = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic logic [7:0] isaWords(input logic [2:0] op);
        return (op < 3'(NUM_OPS)) ? ISA_WORDS[op] : 8'd1;
    endfunction

endpackage

// File: rtl/ccu_isa_fetch_arb_rr_arb.sv
// Combinational round-robin picker: first requester after lastGnt.
// The lastGnt register is owned by the parent.
module ccu_isa_fetch_arb_rr_arb #(
    parameter int N  = 6,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] lastGnt,
    output logic [IW-1:0] gntIdx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        gntIdx = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(lastGnt) + k) % N);
            if (!any && req[cand]) begin
                any    = 1'b1;
                gntIdx = cand;
            end
        end
    end

endmodule

// File: rtl/ccu_isa_fetch_arb.sv
// Fetch scheduler: round-robin one-instruction bursts per stream into CCU.
// Optional ISA_OPCODE_CHECK_EN: verify/force opcode byte on first beat.
module ccu_isa_fetch_arb
    import ccu_isa_fetch_arb_pkg::*;
#(
    parameter int PORT_WIDTH      = 128,
    parameter int OPNUM           = 6,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int NUM_LAYER_WIDTH = 20,
    parameter int NUMWORD_WIDTH   = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               TOPIFA_Start,
    input  logic [OPNUM*DRAM_ADDR_WIDTH-1:0]   TOPIFA_BaseAddr,
    input  logic [OPNUM*NUM_LAYER_WIDTH-1:0]   TOPIFA_NumIns,
    input  logic [OPNUM-1:0]                   CCUIFA_CfgRdy,
    output logic                               IFAITF_RdReqVld,
    input  logic                               ITFIFA_RdReqRdy,
    output logic [DRAM_ADDR_WIDTH-1:0]         IFAITF_RdAddr,
    output logic [NUMWORD_WIDTH-1:0]           IFAITF_RdNum,
    input  logic [PORT_WIDTH-1:0]              ITFIFA_RdDat,
    input  logic                               ITFIFA_RdDatVld,
    input  logic                               ITFIFA_RdDatLast,
    output logic                               IFAITF_RdDatRdy,
    output logic [PORT_WIDTH-1:0]              IFACCU_ISARdDat,
    output logic                               IFACCU_ISARdDatVld,
    output logic                               IFACCU_ISARdDatLast,
    input  logic                               CCUIFA_ISARdDatRdy,
    output logic                               IFATOP_Busy,
    output logic                               IFATOP_Done,
    output logic                               IFATOP_Err
);

    localparam int IW = (OPNUM > 1) ? $clog2(OPNUM) : 1;

    state_e state, stateNxt;

    logic [DRAM_ADDR_WIDTH-1:0] ptr [OPNUM];
    logic [NUM_LAYER_WIDTH-1:0] rem [OPNUM];
    logic [OPNUM-1:0]           remNz;
    logic [OPNUM-1:0]           elig;
    logic [IW-1:0]              gnt, lastGnt, arbIdx;
    logic                       arbAny;
    logic [NUMWORD_WIDTH-1:0]   beatCnt, gntWords;
    logic [DRAM_ADDR_WIDTH-1:0] ptrStep;
    logic                       startAcc, beatHs, finalBeat, opErr;

    always_comb begin
        for (int i = 0; i < OPNUM; i++) begin
            remNz[i] = (rem[i] != '0);
        end
    end

    assign elig      = CCUIFA_CfgRdy & remNz;
    assign gntWords  = NUMWORD_WIDTH'(isaWords(3'(gnt)));
    assign ptrStep   = DRAM_ADDR_WIDTH'(int'(gntWords) * (PORT_WIDTH / 8));
    assign startAcc  = (state == S_IDLE) && TOPIFA_Start;
    assign finalBeat = (beatCnt == gntWords - NUMWORD_WIDTH'(1));
    assign beatHs    = (state == S_XFER) && ITFIFA_RdDatVld
                       && CCUIFA_ISARdDatRdy;

`ifdef ISA_OPCODE_CHECK_EN
    assign opErr = (beatCnt == '0) &&
                   (ITFIFA_RdDat[OPCODE_WIDTH-1:0] != OPCODE_WIDTH'(gnt));
`else
    assign opErr = 1'b0;
`endif

    ccu_isa_fetch_arb_rr_arb #(
        .N  (OPNUM),
        .IW (IW)
    ) uArb (
        .req     (elig),
        .lastGnt (lastGnt),
        .gntIdx  (arbIdx),
        .any     (arbAny)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt            = state;
        IFAITF_RdReqVld     = 1'b0;
        IFAITF_RdAddr       = '0;
        IFAITF_RdNum        = '0;
        IFAITF_RdDatRdy     = 1'b0;
        IFACCU_ISARdDat     = '0;
        IFACCU_ISARdDatVld  = 1'b0;
        IFACCU_ISARdDatLast = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (TOPIFA_Start) stateNxt = S_ARB;
            end
            S_ARB: begin
                if (arbAny)            stateNxt = S_REQ;
                else if (remNz == '0)  stateNxt = S_DONE;
            end
            S_REQ: begin
                IFAITF_RdReqVld = 1'b1;
                IFAITF_RdAddr   = ptr[gnt];
                IFAITF_RdNum    = gntWords;
                if (ITFIFA_RdReqRdy) stateNxt = S_XFER;
            end
            S_XFER: begin
                IFACCU_ISARdDat     = ITFIFA_RdDat;
`ifdef ISA_OPCODE_CHECK_EN
                if (beatCnt == '0) begin
                    IFACCU_ISARdDat[OPCODE_WIDTH-1:0] = OPCODE_WIDTH'(gnt);
                end
`endif
                IFACCU_ISARdDatVld  = ITFIFA_RdDatVld;
                IFACCU_ISARdDatLast = ITFIFA_RdDatVld && finalBeat;
                IFAITF_RdDatRdy     = CCUIFA_ISARdDatRdy;
                if (beatHs && finalBeat) stateNxt = S_ARB;
            end
            S_DONE: begin
                stateNxt = S_IDLE;
            end
            default: begin
                stateNxt = S_IDLE;
            end
        endcase
    end

    assign IFATOP_Busy = (state != S_IDLE);
    assign IFATOP_Done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OPNUM; i++) begin
                ptr[i] <= '0;
                rem[i] <= '0;
            end
            gnt        <= '0;
            lastGnt    <= IW'(OPNUM - 1);
            beatCnt    <= '0;
            IFATOP_Err <= 1'b0;
        end else begin
            if (startAcc) begin
                for (int i = 0; i < OPNUM; i++) begin
                    ptr[i] <= TOPIFA_BaseAddr[i*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
                    rem[i] <= TOPIFA_NumIns[i*NUM_LAYER_WIDTH +: NUM_LAYER_WIDTH];
                end
                lastGnt    <= IW'(OPNUM - 1);
                IFATOP_Err <= 1'b0;
            end
            if (state == S_ARB && arbAny) begin
                gnt     <= arbIdx;
                lastGnt <= arbIdx;
            end
            if (state == S_REQ && ITFIFA_RdReqRdy) begin
                beatCnt <= '0;
            end
            if (beatHs) begin
                beatCnt <= beatCnt + NUMWORD_WIDTH'(1);
                if (opErr) IFATOP_Err <= 1'b1;
                // Transfer length is set by the counter, Last is only checked
                if (finalBeat) begin
                    ptr[gnt] <= ptr[gnt] + ptrStep;
                    rem[gnt] <= rem[gnt] - NUM_LAYER_WIDTH'(1);
                    if (!ITFIFA_RdDatLast) IFATOP_Err <= 1'b1;
                end else if (ITFIFA_RdDatLast) begin
                    IFATOP_Err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccu_isa_fetch_arb.sv
// Scoreboard bench for ccu_isa_fetch_arb with a round-robin reference model.
// Randomized ITF/CCU handshakes; monitor pops expectations on each handshake.
module tb_ccu_isa_fetch_arb;

    localparam int PW = 128;
    localparam int N  = 6;
    localparam int AW = 32;
    localparam int LW = 20;
    localparam int NW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            TOPIFA_Start = 1'b0;
    logic [N*AW-1:0] TOPIFA_BaseAddr = '0;
    logic [N*LW-1:0] TOPIFA_NumIns = '0;
    logic [N-1:0]    CCUIFA_CfgRdy = '1;
    logic            IFAITF_RdReqVld;
    logic            ITFIFA_RdReqRdy = 1'b0;
    logic [AW-1:0]   IFAITF_RdAddr;
    logic [NW-1:0]   IFAITF_RdNum;
    logic [PW-1:0]   ITFIFA_RdDat = '0;
    logic            ITFIFA_RdDatVld = 1'b0;
    logic            ITFIFA_RdDatLast = 1'b0;
    logic            IFAITF_RdDatRdy;
    logic [PW-1:0]   IFACCU_ISARdDat;
    logic            IFACCU_ISARdDatVld;
    logic            IFACCU_ISARdDatLast;
    logic            CCUIFA_ISARdDatRdy = 1'b0;
    logic            IFATOP_Busy;
    logic            IFATOP_Done;
    logic            IFATOP_Err;

    always #5 clk = ~clk;

    ccu_isa_fetch_arb dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .TOPIFA_Start        (TOPIFA_Start),
        .TOPIFA_BaseAddr     (TOPIFA_BaseAddr),
        .TOPIFA_NumIns       (TOPIFA_NumIns),
        .CCUIFA_CfgRdy       (CCUIFA_CfgRdy),
        .IFAITF_RdReqVld     (IFAITF_RdReqVld),
        .ITFIFA_RdReqRdy     (ITFIFA_RdReqRdy),
        .IFAITF_RdAddr       (IFAITF_RdAddr),
        .IFAITF_RdNum        (IFAITF_RdNum),
        .ITFIFA_RdDat        (ITFIFA_RdDat),
        .ITFIFA_RdDatVld     (ITFIFA_RdDatVld),
        .ITFIFA_RdDatLast    (ITFIFA_RdDatLast),
        .IFAITF_RdDatRdy     (IFAITF_RdDatRdy),
        .IFACCU_ISARdDat     (IFACCU_ISARdDat),
        .IFACCU_ISARdDatVld  (IFACCU_ISARdDatVld),
        .IFACCU_ISARdDatLast (IFACCU_ISARdDatLast),
        .CCUIFA_ISARdDatRdy  (CCUIFA_ISARdDatRdy),
        .IFATOP_Busy         (IFATOP_Busy),
        .IFATOP_Done         (IFATOP_Done),
        .IFATOP_Err          (IFATOP_Err)
    );

    typedef struct {
        logic [31:0] addr;
        int          num;
        int          op;
    } req_t;

    typedef struct {
        logic [127:0] dat;
        logic         last;
    } beat_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          wordsOf [6] = '{16, 2, 3, 9, 2, 1};
    int          cnt [6];
    logic [31:0] base [6];
    req_t        reqQ [$];
    req_t        planQ [$];
    beat_t       beatQ [$];

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference: serve streams in round-robin order starting after stream 5
    function automatic void buildExpect();
        int          r [6];
        logic [31:0] p [6];
        int          last;
        bit          found;
        last = 5;
        for (int i = 0; i < 6; i++) begin
            r[i] = cnt[i];
            p[i] = base[i];
        end
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                int j;
                j = (last + k) % 6;
                if (!found && r[j] > 0) begin
                    reqQ.push_back(req_t'{addr: p[j], num: wordsOf[j], op: j});
                    planQ.push_back(req_t'{addr: p[j], num: wordsOf[j], op: j});
                    p[j] = p[j] + 32'(wordsOf[j] * 16);
                    r[j]--;
                    last = j;
                    found = 1'b1;
                end
            end
        end
    endfunction

    always @(negedge clk) begin : monitor
        req_t  r;
        beat_t b;
        if (rst_n) begin
            if (IFAITF_RdReqVld && ITFIFA_RdReqRdy) begin
                if (reqQ.size() == 0) begin
                    chk("req_unexpected", 1, 0);
                end else begin
                    r = reqQ.pop_front();
                    chk("req_addr", IFAITF_RdAddr, r.addr);
                    chk("req_num", IFAITF_RdNum, r.num);
                end
            end
            if (IFACCU_ISARdDatVld && CCUIFA_ISARdDatRdy) begin
                if (beatQ.size() == 0) begin
                    chk("beat_unexpected", 1, 0);
                end else begin
                    b = beatQ.pop_front();
                    chk("beat_data", IFACCU_ISARdDat, b.dat);
                    chk("beat_last", IFACCU_ISARdDatLast, b.last);
                end
            end
        end
    end

    task automatic setCfg(input int c0, input int c1, input int c2,
                          input int c3, input int c4, input int c5);
        cnt = '{c0, c1, c2, c3, c4, c5};
        for (int i = 0; i < 6; i++) begin
            base[i] = $urandom & 32'hFFFF_FFF0;
        end
    endtask

    task automatic pulseStart();
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            TOPIFA_BaseAddr[i*AW +: AW] = base[i];
            TOPIFA_NumIns[i*LW +: LW]   = LW'(cnt[i]);
        end
        TOPIFA_Start = 1'b1;
        @(posedge clk); #1;
        TOPIFA_Start = 1'b0;
        chk("busy_after_start", IFATOP_Busy, 1);
        chk("err_cleared", IFATOP_Err, 0);
    endtask

    // badAt >= 0: extra Last on that beat; badAt == -2: Last never sent
    task automatic serve(input int op, input int num, input int badAt,
                         input int abortAfter, input int ccuMode);
        int           t;
        int           i;
        bit           hs;
        bit           presented;
        logic [127:0] d;
        t = 0;
        hs = 1'b0;
        while (!hs) begin
            @(posedge clk); #1;
            ITFIFA_RdReqRdy = 1'($urandom_range(0, 1));
            #1;
            hs = ITFIFA_RdReqRdy && IFAITF_RdReqVld;
            t++;
            if (t > 200) begin
                chk("req_timeout", 0, 1);
                ITFIFA_RdReqRdy = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        ITFIFA_RdReqRdy = 1'b0;
        i = 0;
        t = 0;
        presented = 1'b0;
        while (i < num) begin
            if (ccuMode == 1) CCUIFA_ISARdDatRdy = ~CCUIFA_ISARdDatRdy;
            else CCUIFA_ISARdDatRdy = ($urandom_range(0, 3) != 0);
            if (!presented && $urandom_range(0, 3) != 0) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                d[7:0] = 8'(op);
                ITFIFA_RdDat     = d;
                ITFIFA_RdDatVld  = 1'b1;
                ITFIFA_RdDatLast = (badAt == -2) ? 1'b0 :
                                   ((i == num - 1) || (i == badAt));
                beatQ.push_back(beat_t'{dat: d, last: (i == num - 1)});
                presented = 1'b1;
            end else if (!presented) begin
                ITFIFA_RdDatVld = 1'b0;
            end
            #1;
            hs = ITFIFA_RdDatVld && IFAITF_RdDatRdy;
            @(posedge clk); #1;
            if (hs) begin
                i++;
                presented = 1'b0;
                ITFIFA_RdDatVld  = 1'b0;
                ITFIFA_RdDatLast = 1'b0;
                if (i == abortAfter) return;
            end
            t++;
            if (t > 400) begin
                chk("beat_timeout", 0, 1);
                ITFIFA_RdDatVld = 1'b0;
                return;
            end
        end
    endtask

    task automatic waitDone(input bit expErr);
        int t;
        t = 0;
        while (!IFATOP_Done && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_pulse", IFATOP_Done, 1);
        chk("done_latency", t, 1);
        chk("err_flag", IFATOP_Err, expErr);
        @(posedge clk); #1;
        chk("done_one_cycle", IFATOP_Done, 0);
        chk("busy_idle", IFATOP_Busy, 0);
        chk("queues_drained", reqQ.size() + beatQ.size(), 0);
    endtask

    task automatic runScenario(input int badOp, input int badAt,
                               input int ccuMode, input bit expErr);
        req_t p;
        planQ.delete();
        buildExpect();
        pulseStart();
        while (planQ.size() > 0) begin
            p = planQ.pop_front();
            serve(p.op, p.num, (p.op == badOp) ? badAt : -1, -1, ccuMode);
        end
        waitDone(expErr);
    endtask

    task automatic checkResetOutputs();
        chk("rst_busy", IFATOP_Busy, 0);
        chk("rst_done", IFATOP_Done, 0);
        chk("rst_err", IFATOP_Err, 0);
        chk("rst_reqvld", IFAITF_RdReqVld, 0);
        chk("rst_reqaddr", {IFAITF_RdAddr, IFAITF_RdNum}, 0);
        chk("rst_datrdy", IFAITF_RdDatRdy, 0);
        chk("rst_isa", {IFACCU_ISARdDatVld, IFACCU_ISARdDatLast}, 0);
        chk("rst_isadat", IFACCU_ISARdDat, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs();
        rst_n = 1'b1;

        setCfg(0, 0, 0, 0, 0, 3);
        base[5] = 32'h1000;
        runScenario(-1, -1, 0, 1'b0);

        setCfg(1, 1, 1, 1, 1, 1);
        runScenario(-1, -1, 0, 1'b0);

        setCfg(2, 0, 0, 0, 0, 0);
        base[0] = 32'hFFFF_FF80;
        runScenario(-1, -1, 0, 1'b0);

        setCfg(0, 0, 0, 1, 0, 0);
        CCUIFA_ISARdDatRdy = 1'b0;
        runScenario(-1, -1, 1, 1'b0);

        // Stall on a busy slot; a Start while busy must be ignored
        setCfg(0, 0, 1, 0, 0, 0);
        CCUIFA_CfgRdy = 6'b111011;
        planQ.delete();
        buildExpect();
        pulseStart();
        TOPIFA_NumIns = {N{20'd3}};
        TOPIFA_Start = 1'b1;
        @(posedge clk); #1;
        TOPIFA_Start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("stall_noreq", IFAITF_RdReqVld, 0);
            @(posedge clk); #1;
        end
        CCUIFA_CfgRdy = '1;
        @(posedge clk); #1;
        chk("stall_release", IFAITF_RdReqVld, 1);
        serve(2, 3, -1, -1, 0);
        planQ.delete();
        waitDone(1'b0);

        setCfg(0, 2, 0, 0, 0, 0);
        runScenario(1, 0, 0, 1'b1);

        setCfg(0, 0, 1, 0, 0, 0);
        runScenario(2, -2, 0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            setCfg($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(1, 3));
            runScenario(-1, -1, 0, 1'b0);
        end

        // Abort mid-burst, then restart with fresh bases
        setCfg(2, 1, 0, 0, 0, 0);
        planQ.delete();
        buildExpect();
        pulseStart();
        serve(0, 16, -1, 5, 0);
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        reqQ.delete();
        beatQ.delete();
        planQ.delete();
        ITFIFA_RdDatVld = 1'b0;
        CCUIFA_ISARdDatRdy = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        setCfg(1, 0, 0, 0, 1, 1);
        runScenario(-1, -1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
